// File: rtl/sp_ram_bytewr.sv
// Single-port synchronous RAM with byte-lane write enables,
// selectable read-during-write behaviour and a read-valid strobe.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    async active-low reset (output registers only)
//   wren_a   write request
//   rden_a   read request
//   addr_a   word address shared by read and write
//   be_a     byte-lane write enables (lane k = bits [k*BYTEW +: BYTEW])
//   wdata_a  write data
//   rdata_a  registered read data
//   rvalid_a one-cycle strobe marking data of an accepted read
//
// Parameters: ABITS, WIDTH, BYTEW, RDW_MODE
//   RDW_MODE 0 = no-change, 1 = read-first, 2 = write-first
//
// Optional build macro: SP_RAM_OUTREG_EN
//   adds a second output register stage (read latency 2).

module sp_ram_bytewr #(
    parameter int ABITS    = 4,
    parameter int WIDTH    = 8,
    parameter int BYTEW    = 8,
    parameter int RDW_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wren_a,
    input  logic                   rden_a,
    input  logic [ABITS-1:0]       addr_a,
    input  logic [WIDTH/BYTEW-1:0] be_a,
    input  logic [WIDTH-1:0]       wdata_a,
    output logic [WIDTH-1:0]       rdata_a,
    output logic                   rvalid_a
);

    localparam int NBE   = WIDTH / BYTEW;
    localparam int DEPTH = 2 ** ABITS;

    localparam logic RD_ON_WR = (RDW_MODE != 0);
    localparam logic WR_FIRST = (RDW_MODE == 2);

    if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_mode
        $error("sp_ram_bytewr: RDW_MODE must be 0, 1 or 2");
    end

    if (WIDTH % BYTEW != 0) begin : g_bad_width
        $error("sp_ram_bytewr: WIDTH must be a multiple of BYTEW");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             rd_acc;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] rdata_d;

    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    // In no-change mode a write blocks the read in the same cycle.
    assign rd_acc = rden_a & (~wren_a | RD_ON_WR);

    // Word as it will look after this cycle's write lands.
    always_comb begin
        merged = mem_q[addr_a];
        for (int k = 0; k < NBE; k++) begin
            if (wren_a && be_a[k]) begin
                merged[k*BYTEW +: BYTEW] = wdata_a[k*BYTEW +: BYTEW];
            end
        end
    end

    always_comb begin
        rdata_d = mem_q[addr_a];
        if (WR_FIRST && wren_a) begin
            rdata_d = merged;
        end
    end

    // Array has no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wren_a) begin
            for (int k = 0; k < NBE; k++) begin
                if (be_a[k]) begin
                    mem_q[addr_a][k*BYTEW +: BYTEW] <=
                        wdata_a[k*BYTEW +: BYTEW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) begin
                rdata_q <= rdata_d;
            end
        end
    end

`ifdef SP_RAM_OUTREG_EN
    logic [WIDTH-1:0] rdata2_q;
    logic             rvalid2_q;

    // Second stage only loads real read data so the hold
    // behaviour is seen at the final output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata2_q  <= '0;
            rvalid2_q <= 1'b0;
        end else begin
            rvalid2_q <= rvalid_q;
            if (rvalid_q) begin
                rdata2_q <= rdata_q;
            end
        end
    end

    assign rdata_a  = rdata2_q;
    assign rvalid_a = rvalid2_q;
`else
    assign rdata_a  = rdata_q;
    assign rvalid_a = rvalid_q;
`endif

endmodule

// File: tb/tb_sp_ram_bytewr.sv
// Directed bench for sp_ram_bytewr: three instances, one per
// read-during-write mode, driven from shared stimulus.

module tb_sp_ram_bytewr;

`ifdef SP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        wren;
    logic        rden;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd [3];
    logic        rv [3];

    int errors;
    int checks;

    sp_ram_bytewr #(.ABITS(4), .WIDTH(32), .BYTEW(8), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wren_a(wren), .rden_a(rden),
        .addr_a(addr), .be_a(be), .wdata_a(wdata),
        .rdata_a(rd[0]), .rvalid_a(rv[0])
    );

    sp_ram_bytewr #(.ABITS(4), .WIDTH(32), .BYTEW(8), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wren_a(wren), .rden_a(rden),
        .addr_a(addr), .be_a(be), .wdata_a(wdata),
        .rdata_a(rd[1]), .rvalid_a(rv[1])
    );

    sp_ram_bytewr #(.ABITS(4), .WIDTH(32), .BYTEW(8), .RDW_MODE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .wren_a(wren), .rden_a(rden),
        .addr_a(addr), .be_a(be), .wdata_a(wdata),
        .rdata_a(rd[2]), .rvalid_a(rv[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [3:0] a, input logic [3:0] b,
                            input logic [31:0] d);
        @(negedge clk);
        wren  = 1'b1;
        addr  = a;
        be    = b;
        wdata = d;
        @(negedge clk);
        wren  = 1'b0;
        be    = 4'h0;
    endtask

    // Leaves the bench at the negedge where read data is visible.
    task automatic issue_read(input logic [3:0] a);
        @(negedge clk);
        rden = 1'b1;
        addr = a;
        @(negedge clk);
        rden = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rd[d] !== 32'h0 || rv[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold dut%0d: rdata=%h rvalid=%b want 0/0",
                         d, rd[d], rv[d]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rd[d] !== 32'h0 || rv[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle dut%0d: rdata=%h rvalid=%b want 0/0",
                         d, rd[d], rv[d]);
            end
        end
    endtask

    task automatic test_full_write;
        do_write(4'd3, 4'hF, 32'hDEADBEEF);
        issue_read(4'd3);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rd[d] !== 32'hDEADBEEF || rv[d] !== 1'b1) begin
                errors++;
                $display("FAIL full_write dut%0d: rdata=%h rvalid=%b want deadbeef/1",
                         d, rd[d], rv[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rd[d] !== 32'hDEADBEEF || rv[d] !== 1'b0) begin
                errors++;
                $display("FAIL rvalid_pulse dut%0d: rdata=%h rvalid=%b want deadbeef/0",
                         d, rd[d], rv[d]);
            end
        end
    endtask

    task automatic test_partial_write;
        do_write(4'd3, 4'b0101, 32'h11223344);
        issue_read(4'd3);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rd[d] !== 32'hDE22BE44 || rv[d] !== 1'b1) begin
                errors++;
                $display("FAIL partial_write dut%0d: rdata=%h rvalid=%b want de22be44/1",
                         d, rd[d], rv[d]);
            end
        end
    endtask

    task automatic test_rdw;
        logic [31:0] exp_d [3];
        logic        exp_v [3];
        exp_d[0] = 32'hDE22BE44; exp_v[0] = 1'b0;
        exp_d[1] = 32'hDE22BE44; exp_v[1] = 1'b1;
        exp_d[2] = 32'hA5A5A5A5; exp_v[2] = 1'b1;
        @(negedge clk);
        wren  = 1'b1;
        rden  = 1'b1;
        addr  = 4'd3;
        be    = 4'hF;
        wdata = 32'hA5A5A5A5;
        @(negedge clk);
        wren = 1'b0;
        rden = 1'b0;
        be   = 4'h0;
        repeat (LAT - 1) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rd[d] !== exp_d[d] || rv[d] !== exp_v[d]) begin
                errors++;
                $display("FAIL rdw_mode%0d: rdata=%h rvalid=%b want %h/%b",
                         d, rd[d], rv[d], exp_d[d], exp_v[d]);
            end
        end
    endtask

    task automatic test_be_zero;
        do_write(4'd3, 4'h0, 32'hFFFFFFFF);
        issue_read(4'd3);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rd[d] !== 32'hA5A5A5A5 || rv[d] !== 1'b1) begin
                errors++;
                $display("FAIL be_zero dut%0d: rdata=%h rvalid=%b want a5a5a5a5/1",
                         d, rd[d], rv[d]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  a;
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) begin
            a = i[3:0];
            do_write(a, 4'hF, 32'h01010101 * i);
        end
        // 17 reads: 0..15 then wrap to 0.
        for (int c = 0; c < 17 + LAT; c++) begin
            @(negedge clk);
            if (c >= LAT) begin
                exp = 32'h01010101 * ((c - LAT) % 16);
                for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (rd[d] !== exp || rv[d] !== 1'b1) begin
                        errors++;
                        $display("FAIL stream[%0d] dut%0d: rdata=%h rvalid=%b want %h/1",
                                 c - LAT, d, rd[d], rv[d], exp);
                    end
                end
            end
            if (c < 17) begin
                rden = 1'b1;
                addr = c[3:0];
            end else begin
                rden = 1'b0;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rv[d] !== 1'b0 || rd[d] !== 32'h0) begin
                errors++;
                $display("FAIL stream_end dut%0d: rdata=%h rvalid=%b want 0/0",
                         d, rd[d], rv[d]);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        issue_read(4'd5);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rd[d] !== 32'h05050505 || rv[d] !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset_read dut%0d: rdata=%h rvalid=%b want 05050505/1",
                         d, rd[d], rv[d]);
            end
        end
        @(negedge clk);
        rden = 1'b1;
        addr = 4'd3;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rden = 1'b0;
        repeat (LAT) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rd[d] !== 32'h0 || rv[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_read dut%0d: rdata=%h rvalid=%b want 0/0",
                         d, rd[d], rv[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rv[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release dut%0d: rvalid=%b want 0",
                         d, rv[d]);
            end
        end
        issue_read(4'd3);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rd[d] !== 32'h03030303 || rv[d] !== 1'b1) begin
                errors++;
                $display("FAIL retained dut%0d: rdata=%h rvalid=%b want 03030303/1",
                         d, rd[d], rv[d]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        wren   = 1'b0;
        rden   = 1'b0;
        addr   = 4'h0;
        be     = 4'h0;
        wdata  = 32'h0;
        test_reset();
        test_full_write();
        test_partial_write();
        test_rdw();
        test_be_zero();
        test_back_to_back();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
